// File: rtl/cdc_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package cdc_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH = 32;

  // Pointer width: index bits plus one wrap bit so full and empty differ.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cdc_fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read
// port so the head word falls straight through to the consumer.
module cdc_fifo_mem
  import cdc_fifo_pkg::*;
#(
  parameter int DataWidth = DEFAULT_DATA_WIDTH,
  parameter int FifoDepth = DEFAULT_FIFO_DEPTH,
  parameter int AddrWidth = $clog2(FifoDepth)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem [FifoDepth];

  // Storage is never cleared; the pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cdc_fifo.sv
// First-word-fall-through FIFO on one clock, keeping the dual-domain
// interface names so it drops into the same sockets as the async variants.
module cdc_fifo
  import cdc_fifo_pkg::*;
#(
  parameter int DataWidth = DEFAULT_DATA_WIDTH,
  parameter int FifoDepth = DEFAULT_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Push_DA,
  input  logic [DataWidth-1:0] DataIn_DA,
  output logic                 FifoFull_DA,
  input  logic                 Deq_DB,
  output logic                 DataValid_DB,
  output logic [DataWidth-1:0] DataOut_DB
);

  localparam int PtrWidth = ptr_width(FifoDepth);
  localparam int IdxWidth = PtrWidth - 1;
  localparam logic [PtrWidth-1:0] PtrOne = {{(PtrWidth-1){1'b0}}, 1'b1};

  // The wrap-bit full/empty scheme only works for power-of-two depths.
  generate
    if ((FifoDepth < 2) || ((FifoDepth & (FifoDepth - 1)) != 0)) begin : g_bad_depth
      $error("cdc_fifo: FifoDepth must be a power of two and at least 2");
    end
  endgenerate

  logic [PtrWidth-1:0]  wr_ptr;
  logic [PtrWidth-1:0]  rd_ptr;
  logic                 empty;
  logic                 full;
  logic                 push_ok;
  logic                 pop_ok;
  logic                 mem_we;
  logic [DataWidth-1:0] head_word;

  // Flags depend only on registered pointers, so no input reaches an output
  // combinationally.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IdxWidth-1:0] == rd_ptr[IdxWidth-1:0]) &&
                 (wr_ptr[IdxWidth] != rd_ptr[IdxWidth]);

  assign FifoFull_DA  = full;
  assign DataValid_DB = ~empty;

  // Overflowing pushes and underflowing pops are simply not accepted.
  assign push_ok = Push_DA & ~full;
  assign pop_ok  = Deq_DB & ~empty;

  // A push in a reset cycle must not disturb storage either.
  assign mem_we = push_ok & rst_n;

  // Pointer registers; reset discards contents and ignores that cycle's requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PtrOne;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PtrOne;
      end
    end
  end

  cdc_fifo_mem #(
    .DataWidth (DataWidth),
    .FifoDepth (FifoDepth),
    .AddrWidth (IdxWidth)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr[IdxWidth-1:0]),
    .wdata (DataIn_DA),
    .raddr (rd_ptr[IdxWidth-1:0]),
    .rdata (head_word)
  );

  // Stale storage is masked so an empty FIFO always presents zero.
  assign DataOut_DB = DataValid_DB ? head_word : '0;

endmodule

// File: tb/tb_cdc_fifo.sv
// Scoreboard bench for cdc_fifo: the driver queues every word it expects the
// FIFO to accept, and a negedge monitor checks flags and the head word.
module tb_cdc_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst_n;
  logic          Push_DA;
  logic [DW-1:0] DataIn_DA;
  logic          FifoFull_DA;
  logic          Deq_DB;
  logic          DataValid_DB;
  logic [DW-1:0] DataOut_DB;

  logic [DW-1:0] exp_q[$];
  int            model_count;
  int            n_vec;
  int            n_err;
  bit            mon_en;

  cdc_fifo #(
    .DataWidth (DW),
    .FifoDepth (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Push_DA      (Push_DA),
    .DataIn_DA    (DataIn_DA),
    .FifoFull_DA  (FifoFull_DA),
    .Deq_DB       (Deq_DB),
    .DataValid_DB (DataValid_DB),
    .DataOut_DB   (DataOut_DB)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: bump the counters and report any difference.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and update the reference model at the edge.
  task automatic applyStimulus(input logic r, input logic p, input logic [DW-1:0] d,
                               input logic q, output bit accepted);
    bit pa;
    bit qa;
    rst_n     = r;
    Push_DA   = p;
    DataIn_DA = d;
    Deq_DB    = q;
    pa = r && p && (model_count < DEPTH);
    qa = r && q && (model_count > 0);
    @(posedge clk);
    if (!r) begin
      model_count = 0;
      exp_q.delete();
    end else begin
      if (pa) exp_q.push_back(d);
      model_count = model_count + (pa ? 1 : 0) - (qa ? 1 : 0);
    end
    accepted = pa;
    #1;
  endtask

  // Monitor: flags against the model, head word against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("valid", {31'b0, DataValid_DB}, {31'b0, model_count != 0});
      checkOutput("full", {31'b0, FifoFull_DA}, {31'b0, model_count == DEPTH});
      if (DataValid_DB) begin
        if (exp_q.size() > 0) begin
          checkOutput("dout", {24'b0, DataOut_DB}, {24'b0, exp_q[0]});
          if (Deq_DB) void'(exp_q.pop_front());
        end
      end else begin
        checkOutput("dout_idle", {24'b0, DataOut_DB}, 32'h0);
      end
    end
  end

  initial begin
    bit          acc;
    logic [DW-1:0] val;
    n_vec       = 0;
    n_err       = 0;
    model_count = 0;
    mon_en      = 1'b0;
    rst_n       = 1'b0;
    Push_DA     = 1'b0;
    DataIn_DA   = '0;
    Deq_DB      = 1'b0;

    // Reset held 5 cycles with both requests high.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h3C, 1'b1, acc);
      mon_en = 1'b1;
    end

    // Fill: value advances only on accepted pushes; extra pushes are dropped.
    val = 8'd0;
    for (int i = 0; i < 36; i++) begin
      applyStimulus(1'b1, 1'b1, val, 1'b0, acc);
      if (acc) val = val + 8'd1;
    end
    checkOutput("fill_count", {24'b0, val}, 32'd32);

    // Drain everything, then idle with Deq still high.
    for (int i = 0; i < 34; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, acc);

    // Streaming across several pointer wraps.
    for (int i = 0; i < 80; i++) applyStimulus(1'b1, 1'b1, 8'(i), 1'b1, acc);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, acc);

    // Full boundary: simultaneous push and pop while full.
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b1, 8'(i), 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 8'hEE, 1'b1, acc);
    checkOutput("full_push_rejected", {31'b0, acc}, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, acc);
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, acc);

    // Reset mid-operation with 10 words stored.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 8'(8'h40 + i), 1'b0, acc);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 8'hA5, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, acc);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, acc);

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
